// File: rtl/mem_arbiter.sv
// Arbitrates one block-wide main memory port between the I-cache and D-cache miss ports.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              INST_MEM_READ,
    input  logic [ADDR_W-1:0] INST_MEM_ADDRESS,
    output logic [DATA_W-1:0] INST_MEM_READDATA,
    output logic              INST_MEM_BUSYWAIT,
    input  logic              DATA_MEM_READ,
    input  logic              DATA_MEM_WRITE,
    input  logic [ADDR_W-1:0] DATA_MEM_ADDRESS,
    input  logic [DATA_W-1:0] DATA_MEM_WRITEDATA,
    output logic [DATA_W-1:0] DATA_MEM_READDATA,
    output logic              DATA_MEM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       INST_GRANT_CNT,
    output logic [31:0]       DATA_GRANT_CNT,
    output logic [31:0]       CONFLICT_CNT
`endif
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {G_NONE, G_INST, G_DATA} grant_t;

    state_t            state, state_nxt;
    grant_t            grant;
    logic              cmd_write;
    logic              wb_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SC_W-1:0]   starve_cnt;

    logic i_req, d_req, any_req, starved, pick_d;

    assign i_req   = INST_MEM_READ;
    assign d_req   = DATA_MEM_READ | DATA_MEM_WRITE;
    assign any_req = i_req | d_req;
    assign starved = (starve_cnt == SC_W'(STARVE_LIMIT));
    assign pick_d  = d_req && !(i_req && starved);

    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        MEM_READ          = 1'b0;
        MEM_WRITE         = 1'b0;
        INST_MEM_BUSYWAIT = i_req;
        DATA_MEM_BUSYWAIT = d_req;
        case (state)
            IDLE:  if (any_req) state_nxt = ISSUE;
            ISSUE: begin
                MEM_READ  = !cmd_write;
                MEM_WRITE = cmd_write;
                state_nxt = WAIT;
            end
            WAIT: begin
                MEM_READ  = !cmd_write;
                MEM_WRITE = cmd_write;
                if (!MEM_BUSYWAIT) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                if (grant == G_INST) INST_MEM_BUSYWAIT = 1'b0;
                // a writeback that still has its refill pending keeps the D side stalled
                if (grant == G_DATA && !wb_done) DATA_MEM_BUSYWAIT = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            grant             <= G_NONE;
            cmd_write         <= 1'b0;
            wb_done           <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            starve_cnt        <= '0;
            INST_MEM_READDATA <= '0;
            DATA_MEM_READDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!DATA_MEM_READ) wb_done <= 1'b0;
                    if (any_req) begin
                        if (pick_d) begin
                            grant     <= G_DATA;
                            addr_q    <= DATA_MEM_ADDRESS;
                            wdata_q   <= DATA_MEM_WRITEDATA;
                            cmd_write <= DATA_MEM_WRITE && !(wb_done && DATA_MEM_READ);
                            if (i_req && !starved) starve_cnt <= starve_cnt + SC_W'(1);
                        end else begin
                            grant      <= G_INST;
                            addr_q     <= INST_MEM_ADDRESS;
                            cmd_write  <= 1'b0;
                            starve_cnt <= '0;
                        end
                    end
                end
                WAIT: if (!MEM_BUSYWAIT) begin
                    // data for a withdrawn request is dropped, not captured
                    if (grant == G_INST && !cmd_write && INST_MEM_READ)
                        INST_MEM_READDATA <= MEM_READDATA;
                    if (grant == G_DATA) begin
                        if (!cmd_write && DATA_MEM_READ) DATA_MEM_READDATA <= MEM_READDATA;
                        wb_done <= cmd_write && DATA_MEM_READ;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            INST_GRANT_CNT <= '0;
            DATA_GRANT_CNT <= '0;
            CONFLICT_CNT   <= '0;
        end else if (state == IDLE && any_req) begin
            if (pick_d) DATA_GRANT_CNT <= DATA_GRANT_CNT + 32'd1;
            else        INST_GRANT_CNT <= INST_GRANT_CNT + 32'd1;
            if (i_req && d_req) CONFLICT_CNT <= CONFLICT_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/priority/reset cases, then random traffic
// against a scoreboard, a memory slave model and a starvation reference model.
module tb_mem_arbiter;
    localparam int AW  = 28;
    localparam int DW  = 128;
    localparam int LIM = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          INST_MEM_READ;
    logic [AW-1:0] INST_MEM_ADDRESS;
    logic [DW-1:0] INST_MEM_READDATA;
    logic          INST_MEM_BUSYWAIT;
    logic          DATA_MEM_READ, DATA_MEM_WRITE;
    logic [AW-1:0] DATA_MEM_ADDRESS;
    logic [DW-1:0] DATA_MEM_WRITEDATA;
    logic [DW-1:0] DATA_MEM_READDATA;
    logic          DATA_MEM_BUSYWAIT;
    logic          MEM_READ, MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [DW-1:0] MEM_WRITEDATA;
    logic [DW-1:0] MEM_READDATA;
    logic          MEM_BUSYWAIT;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   INST_GRANT_CNT, DATA_GRANT_CNT, CONFLICT_CNT;
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RESET(RESET),
        .INST_MEM_READ(INST_MEM_READ), .INST_MEM_ADDRESS(INST_MEM_ADDRESS),
        .INST_MEM_READDATA(INST_MEM_READDATA), .INST_MEM_BUSYWAIT(INST_MEM_BUSYWAIT),
        .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE),
        .DATA_MEM_ADDRESS(DATA_MEM_ADDRESS), .DATA_MEM_WRITEDATA(DATA_MEM_WRITEDATA),
        .DATA_MEM_READDATA(DATA_MEM_READDATA), .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef MEM_ARB_PERF_EN
        ,
        .INST_GRANT_CNT(INST_GRANT_CNT), .DATA_GRANT_CNT(DATA_GRANT_CNT),
        .CONFLICT_CNT(CONFLICT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        if (a == 28'h0000010) return {16{8'hA5}};
        return {4'h3, a, 4'h7, ~a, 4'hC, a ^ 28'h5A5A5A5, 4'h9, a + 28'd77};
    endfunction

    // memory slave: busy for mem_lat cycles after the strobe is seen, then data/ack
    logic [DW-1:0] smem [256];
    bit   [255:0]  swr;
    logic          sbusy, sdone, swrite;
    logic [AW-1:0] saddr;
    logic [DW-1:0] swdata;
    int            scnt;
    int            mem_lat = 2;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sbusy <= 1'b0; sdone <= 1'b0; swrite <= 1'b0; scnt <= 0;
            MEM_BUSYWAIT <= 1'b0; MEM_READDATA <= '0; saddr <= '0; swdata <= '0;
        end else if (!sbusy && !sdone && (MEM_READ || MEM_WRITE)) begin
            sbusy <= 1'b1; MEM_BUSYWAIT <= 1'b1; scnt <= mem_lat;
            saddr <= MEM_ADDRESS; swdata <= MEM_WRITEDATA; swrite <= MEM_WRITE;
        end else if (sbusy) begin
            if (scnt == 1) begin
                sbusy <= 1'b0; sdone <= 1'b1; MEM_BUSYWAIT <= 1'b0;
                if (swrite) begin
                    smem[saddr[7:0]] <= swdata;
                    swr[saddr[7:0]]  <= 1'b1;
                end else begin
                    MEM_READDATA <= swr[saddr[7:0]] ? smem[saddr[7:0]] : mem_init(saddr);
                end
            end else begin
                scnt <= scnt - 1;
            end
        end else if (sdone && !(MEM_READ || MEM_WRITE)) begin
            sdone <= 1'b0;
        end
    end

    // reference memory image, updated when a write is issued
    logic [DW-1:0] ref_mem [256];
    bit   [255:0]  ref_w;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_w[a[7:0]] ? ref_mem[a[7:0]] : mem_init(a);
    endfunction

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    bit   mon_en = 1'b0;
    int   starve_m = 0;
    int   forced_cnt = 0;

    // monitor: completions pop the scoreboard; new strobes are checked against the priority model
    initial begin
        txn_t t;
        logic s_now, s_prev, gr_d, both;
        s_prev = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (mon_en) begin
                s_now = MEM_READ | MEM_WRITE;
                if (s_now && !s_prev) begin
                    gr_d = MEM_ADDRESS[7];
                    both = INST_MEM_READ && (DATA_MEM_READ || DATA_MEM_WRITE);
                    if (both) begin
                        chk("arb_grant_d", gr_d, starve_m < LIM);
                        if (starve_m >= LIM) forced_cnt++;
                    end
                    if (gr_d && INST_MEM_READ) starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
                    else if (!gr_d)            starve_m = 0;
                end
                s_prev = s_now;
                if (INST_MEM_READ && !INST_MEM_BUSYWAIT) begin
                    chk("i_queue_nonempty", iq.size() > 0, 1);
                    if (iq.size() > 0) begin
                        t = iq.pop_front();
                        chk("i_rdata", INST_MEM_READDATA, t.exp);
                    end
                end
                if ((DATA_MEM_READ || DATA_MEM_WRITE) && !DATA_MEM_BUSYWAIT) begin
                    chk("d_queue_nonempty", dq.size() > 0, 1);
                    if (dq.size() > 0) begin
                        t = dq.pop_front();
                        if (t.rd) chk("d_rdata", DATA_MEM_READDATA, t.exp);
                        if (t.wr) chk("d_wmem", smem[t.addr[7:0]], t.wdata);
                    end
                end
            end else begin
                s_prev = 1'b0;
            end
        end
    end

    logic [AW-1:0] rd_addr;

    // directed transfer runner; returns the cycle (request cycle = 0) of each event
    task automatic run_xfer(output int i_cyc, output int d_cyc, output int wr_cyc, output int rd_cyc);
        i_cyc = 0; d_cyc = 0; wr_cyc = 0; rd_cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge CLK); #1;
            if (MEM_WRITE && wr_cyc == 0) wr_cyc = c;
            if (MEM_READ && rd_cyc == 0) begin rd_cyc = c; rd_addr = MEM_ADDRESS; end
            if (INST_MEM_READ && !INST_MEM_BUSYWAIT) i_cyc = c;
            if ((DATA_MEM_READ || DATA_MEM_WRITE) && !DATA_MEM_BUSYWAIT) d_cyc = c;
            @(negedge CLK);
            if (i_cyc != 0) INST_MEM_READ = 1'b0;
            if (d_cyc != 0) begin DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0; end
            if (!INST_MEM_READ && !DATA_MEM_READ && !DATA_MEM_WRITE) break;
        end
    endtask

    task automatic i_proc(input int n);
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, 3);
            int w;
            logic [AW-1:0] a;
            txn_t t;
            repeat (gap) @(negedge CLK);
            a = {20'h0, 1'b0, 7'($urandom)};
            t.rd = 1'b1; t.wr = 1'b0; t.addr = a; t.wdata = '0; t.exp = ref_rd(a);
            iq.push_back(t);
            INST_MEM_ADDRESS = a; INST_MEM_READ = 1'b1;
            w = 0;
            do begin @(negedge CLK); w++; end while (INST_MEM_BUSYWAIT && w < 200);
            chk("i_done_in_budget", INST_MEM_BUSYWAIT, 1'b0);
            INST_MEM_READ = 1'b0;
        end
    endtask

    task automatic d_proc(input int n, input int gmax);
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, gmax);
            int kind = $urandom_range(0, 2);
            int w;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            txn_t t;
            repeat (gap) @(negedge CLK);
            a  = {20'h0, 1'b1, 7'($urandom)};
            wd = {$urandom, $urandom, $urandom, $urandom};
            t.rd = (kind != 1); t.wr = (kind != 0); t.addr = a; t.wdata = wd;
            if (t.wr) begin ref_mem[a[7:0]] = wd; ref_w[a[7:0]] = 1'b1; end
            t.exp = ref_rd(a);
            dq.push_back(t);
            DATA_MEM_ADDRESS = a; DATA_MEM_WRITEDATA = wd;
            DATA_MEM_READ = t.rd; DATA_MEM_WRITE = t.wr;
            w = 0;
            do begin @(negedge CLK); w++; end while (DATA_MEM_BUSYWAIT && w < 200);
            chk("d_done_in_budget", DATA_MEM_BUSYWAIT, 1'b0);
            DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
        end
    endtask

    initial begin
        int ic, dc, wc, rc;
        logic [DW-1:0] wd5;
        RESET = 1'b0;
        INST_MEM_READ = 1'b0; INST_MEM_ADDRESS = '0;
        DATA_MEM_READ = 1'b0; DATA_MEM_WRITE = 1'b0;
        DATA_MEM_ADDRESS = '0; DATA_MEM_WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        chk("rst_mem_read", MEM_READ, 1'b0);
        chk("rst_mem_write", MEM_WRITE, 1'b0);
        chk("rst_mem_addr", MEM_ADDRESS, '0);
        chk("rst_mem_wdata", MEM_WRITEDATA, '0);
        chk("rst_i_rdata", INST_MEM_READDATA, '0);
        chk("rst_d_rdata", DATA_MEM_READDATA, '0);
        chk("rst_i_busy", INST_MEM_BUSYWAIT, 1'b0);
        chk("rst_d_busy", DATA_MEM_BUSYWAIT, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);

        // single I read, latency 5 -> busywait low at cycle 8
        mem_lat = 5;
        INST_MEM_ADDRESS = 28'h0000010; INST_MEM_READ = 1'b1;
        run_xfer(ic, dc, wc, rc);
        chk("lat_i_done_cycle", ic, 8);
        chk("lat_issue_cycle", rc, 1);
        chk("lat_issue_addr", rd_addr, 28'h0000010);
        chk("lat_i_rdata", INST_MEM_READDATA, {16{8'hA5}});

        // reset while in WAIT
        @(negedge CLK);
        mem_lat = 10;
        INST_MEM_ADDRESS = 28'h0000011; INST_MEM_READ = 1'b1;
        repeat (4) @(negedge CLK);
        chk("mid_wait_read", MEM_READ, 1'b1);
        RESET = 1'b0; #1;
        chk("rstw_mem_read", MEM_READ, 1'b0);
        chk("rstw_mem_write", MEM_WRITE, 1'b0);
        chk("rstw_i_rdata", INST_MEM_READDATA, '0);
        chk("rstw_d_rdata", DATA_MEM_READDATA, '0);
        chk("rstw_i_busy", INST_MEM_BUSYWAIT, 1'b1);
        INST_MEM_READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        mem_lat = 2;
        INST_MEM_ADDRESS = 28'h0000012; INST_MEM_READ = 1'b1;
        run_xfer(ic, dc, wc, rc);
        chk("post_rst_i_done_cycle", ic, 5);
        chk("post_rst_i_rdata", INST_MEM_READDATA, mem_init(28'h0000012));

        // simultaneous I and D reads: D first, I right after
        @(negedge CLK);
        mem_lat = 3;
        INST_MEM_ADDRESS = 28'h0000013; INST_MEM_READ = 1'b1;
        DATA_MEM_ADDRESS = 28'h0000090; DATA_MEM_READ = 1'b1;
        run_xfer(ic, dc, wc, rc);
        chk("prio_d_done_cycle", dc, 6);
        chk("prio_i_done_cycle", ic, 13);
        chk("prio_first_addr", rd_addr, 28'h0000090);
        chk("prio_d_rdata", DATA_MEM_READDATA, mem_init(28'h0000090));
        chk("prio_i_rdata", INST_MEM_READDATA, mem_init(28'h0000013));

        // D read+write together: writeback first, then refill of the written block
        @(negedge CLK);
        mem_lat = 2;
        wd5 = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        ref_mem[8'h20] = wd5; ref_w[8'h20] = 1'b1;
        DATA_MEM_ADDRESS = 28'h0000020; DATA_MEM_WRITEDATA = wd5;
        DATA_MEM_READ = 1'b1; DATA_MEM_WRITE = 1'b1;
        run_xfer(ic, dc, wc, rc);
        chk("wb_write_cycle", wc, 1);
        chk("wb_read_cycle", rc, 7);
        chk("wb_d_done_cycle", dc, 11);
        chk("wb_mem_content", smem[8'h20], wd5);
        chk("wb_d_rdata", DATA_MEM_READDATA, wd5);
`ifdef MEM_ARB_PERF_EN
        chk("perf_inst_grants", INST_GRANT_CNT, 2);
        chk("perf_data_grants", DATA_GRANT_CNT, 3);
        chk("perf_conflicts", CONFLICT_CNT, 1);
`endif

        // random traffic, then sustained D traffic to exercise the starvation limit
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        starve_m = 0;
        mon_en = 1'b1;
        fork
            i_proc(40);
            d_proc(40, 3);
        join
        fork
            i_proc(30);
            d_proc(60, 0);
        join
        repeat (3) @(negedge CLK);
        mon_en = 1'b0;
        chk("i_queue_drained", iq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);
        chk("starve_forced_grant_seen", forced_cnt > 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
